// File: rtl/ota_test_pkg.sv
// Shared types, defaults and helpers for the OTA offset SAR measurement engine.
package ota_test_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned DEF_N_BITS        = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 1024;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ota_pwm_dac.sv
// 1-bit PWM DAC: free-running period counter compared against the trial code.
module ota_pwm_dac
  import ota_test_pkg::*;
#(
  parameter int unsigned N_BITS = DEF_N_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [N_BITS-1:0] code,
  output logic              pwm_out
);

  logic [N_BITS-1:0] pcnt;

  // Period counter wraps naturally at 2^N_BITS; the output is the registered compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt    <= '0;
      pwm_out <= 1'b0;
    end else begin
      if (clr) begin
        pcnt <= '0;
      end else if (en) begin
        pcnt <= pcnt + N_BITS'(1);
      end else begin
        pcnt <= pcnt;
      end
      pwm_out <= en & (pcnt < code);
    end
  end

endmodule

// File: rtl/ota_offset_sar.sv
// Stimulus-and-measure engine: PWM-driven VIN+ plus a comparator-based
// successive-approximation search for the OTA trip code.
module ota_offset_sar
  import ota_test_pkg::*;
#(
  parameter int unsigned N_BITS        = DEF_N_BITS,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cmp_in,
  output logic              pwm_out,
  output logic              busy,
  output logic              done,
  output logic [N_BITS-1:0] result,
  output logic              result_valid
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  state_t            state, state_nx;
  logic              cmp_s1, cmp_s2;
  logic [SW-1:0]     settle_cnt, settle_cnt_nx;
  logic [1:0]        samp_cnt, samp_cnt_nx;
  logic [1:0]        caps, caps_nx;
  logic [BW-1:0]     bit_idx, bit_idx_nx;
  logic [N_BITS-1:0] code, code_nx, code_tmp, result_nx;
  logic              busy_nx, done_nx, valid_nx, pwm_clr, decision;

  // Next-state, SAR update and output intent; every target defaulted first.
  always_comb begin
    state_nx      = state;
    settle_cnt_nx = settle_cnt;
    samp_cnt_nx   = samp_cnt;
    caps_nx       = caps;
    bit_idx_nx    = bit_idx;
    code_nx       = code;
    code_tmp      = code;
    result_nx     = result;
    valid_nx      = result_valid;
    done_nx       = 1'b0;
    pwm_clr       = 1'b0;
    decision      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          bit_idx_nx    = BW'(N_BITS - 1);
          code_nx       = N_BITS'(1) << (N_BITS - 1);
          settle_cnt_nx = '0;
          samp_cnt_nx   = 2'd0;
          valid_nx      = 1'b0;
          pwm_clr       = 1'b1;
          state_nx      = SETTLE;
        end else begin
          state_nx = IDLE;
        end
      end
      SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
          samp_cnt_nx = 2'd0;
          state_nx    = SAMPLE;
        end else begin
          settle_cnt_nx = settle_cnt + SW'(1);
        end
      end
      SAMPLE: begin
        if (samp_cnt == 2'd2) begin
          // Third capture is the live synchronized value; vote across all three.
          decision = maj3(caps[0], caps[1], cmp_s2);
          if (decision) begin
            code_tmp[bit_idx] = 1'b0;
          end else begin
            code_tmp[bit_idx] = 1'b1;
          end
          if (bit_idx != '0) begin
            bit_idx_nx              = bit_idx - BW'(1);
            code_tmp[bit_idx - BW'(1)] = 1'b1;
            settle_cnt_nx           = '0;
            pwm_clr                 = 1'b1;
            state_nx                = SETTLE;
          end else begin
            result_nx = code_tmp;
            valid_nx  = 1'b1;
            done_nx   = 1'b1;
            state_nx  = DONE;
          end
          code_nx = code_tmp;
        end else begin
          caps_nx[samp_cnt[0]] = cmp_s2;
          samp_cnt_nx          = samp_cnt + 2'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx == SETTLE) || (state_nx == SAMPLE);
  end

  // State, SAR registers, comparator synchronizer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cmp_s1       <= 1'b0;
      cmp_s2       <= 1'b0;
      settle_cnt   <= '0;
      samp_cnt     <= 2'd0;
      caps         <= 2'd0;
      bit_idx      <= '0;
      code         <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nx;
      cmp_s1       <= cmp_in;
      cmp_s2       <= cmp_s1;
      settle_cnt   <= settle_cnt_nx;
      samp_cnt     <= samp_cnt_nx;
      caps         <= caps_nx;
      bit_idx      <= bit_idx_nx;
      code         <= code_nx;
      result       <= result_nx;
      result_valid <= valid_nx;
      busy         <= busy_nx;
      done         <= done_nx;
    end
  end

  // Counter restarts on each new trial code and is parked at 0 outside a run.
  ota_pwm_dac #(.N_BITS(N_BITS)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .en      (busy),
    .clr     (pwm_clr | ~busy_nx),
    .code    (code),
    .pwm_out (pwm_out)
  );

endmodule
